// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-input, W-bit round-robin arbitrated registered multiplexer.
// Channels present valid/ready handshakes; one word per cycle is forwarded
// from the granted channel into a single output register with backpressure.
// Optional feature macro: MUX_RR_SEL_OVERRIDE_EN adds sel_en/sel inputs that
// restrict the request set to a single externally selected channel.
module mux_rr_arb #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [PTR_W-1:0] out_ch,
  input  logic             out_ready
`ifdef MUX_RR_SEL_OVERRIDE_EN
  ,
  input  logic             sel_en,
  input  logic [PTR_W-1:0] sel
`endif
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [PTR_W-1:0] r_out_ch;
  logic [PTR_W-1:0] r_last;

  logic             w_load_en;
  logic [N-1:0]     w_req;
  logic             w_any;
  logic [PTR_W-1:0] w_grant;
  logic [N-1:0]     w_grant_oh;
  logic [W-1:0]     w_grant_data;

  // The output register may accept a new word when empty or draining now.
  assign w_load_en = !r_out_valid || out_ready;

  // Build the request set, optionally narrowed to the selected channel.
  always_comb begin
    w_req = in_valid;
`ifdef MUX_RR_SEL_OVERRIDE_EN
    if (sel_en) begin
      w_req = '0;
      for (int i = 0; i < N; i++) begin
        if (sel == PTR_W'(i)) begin
          w_req[i] = in_valid[i];
        end else begin
          w_req[i] = 1'b0;
        end
      end
    end else begin
      w_req = in_valid;
    end
`endif
  end

  // Pick the requester closest above r_last (wrapping), i.e. smallest distance.
  always_comb begin
    int best_d;
    int d;
    w_any   = 1'b0;
    w_grant = '0;
    best_d  = N;
    d       = 0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(r_last) - 1;
      if (d < 0) begin
        d = d + N;
      end else begin
        d = d;
      end
      if (w_req[i] && (d < best_d)) begin
        best_d  = d;
        w_any   = 1'b1;
        w_grant = PTR_W'(i);
      end else begin
        best_d  = best_d;
      end
    end
  end

  // Decode the grant into a one-hot strobe and select the granted word.
  always_comb begin
    w_grant_oh   = '0;
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == PTR_W'(i)) begin
        w_grant_oh[i] = 1'b1;
        w_grant_data  = in_data[i*W +: W];
      end else begin
        w_grant_oh[i] = 1'b0;
      end
    end
  end

  // Accept strobe: only while out of reset, loadable and something requests.
  always_comb begin
    if (rst_n && w_load_en && w_any) begin
      in_ready = w_grant_oh;
    end else begin
      in_ready = '0;
    end
  end

  // Output register and round-robin pointer; a grant implies a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_last      <= PTR_W'(N - 1);
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_ch    <= w_grant;
        r_last      <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Self-checking bench for mux_rr_arb (N=4, W=4): directed steps from the
// test plan followed by randomized traffic against a transaction-level model.
module tb_mux_rr_arb;
  localparam int N = 4;
  localparam int W = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [PTR_W-1:0] out_ch;
  logic             out_ready;
`ifdef MUX_RR_SEL_OVERRIDE_EN
  logic             sel_en;
  logic [PTR_W-1:0] sel;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: output register contents and index of last winner.
  int         m_last;
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_ch;

  mux_rr_arb #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
`ifdef MUX_RR_SEL_OVERRIDE_EN
    , .sel_en(sel_en), .sel(sel)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
  endtask

  function automatic bit eligible(input int c);
`ifdef MUX_RR_SEL_OVERRIDE_EN
    if (sel_en) return (in_valid[c] && (c == int'(sel)));
`endif
    return in_valid[c];
  endfunction

  // Winner = first eligible channel in the rotated order last+1, last+2, ...
  function automatic int model_grant();
    int order[$];
    if (m_valid && !out_ready) return -1;
    for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
    foreach (order[j]) if (eligible(order[j])) return order[j];
    return -1;
  endfunction

  // One clock: check accept strobe, clock, update model, check outputs.
  task automatic tick(input string tag);
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!(m_valid && !out_ready)) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_ch    = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
    chk({tag, ".out_ch"},    32'(out_ch),    32'(m_ch));
    @(negedge clk);
  endtask

  int exp_rr_ch [5];
  logic [3:0] exp_rr_data [5];

  initial begin
    exp_rr_ch   = '{0, 1, 2, 3, 0};
    exp_rr_data = '{4'b1110, 4'b1010, 4'b1011, 4'b0010, 4'b1110};
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {4'b0010, 4'b1011, 4'b1010, 4'b1110};
    out_ready = 1'b1;
`ifdef MUX_RR_SEL_OVERRIDE_EN
    sel_en = 1'b0;
    sel    = '0;
`endif
    model_reset();

    // Reset held with all channels valid.
    @(negedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_ch",    32'(out_ch),    32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin across all four channels.
    for (int i = 0; i < 5; i++) begin
      tick("rr");
      chk("rr.seq_ch",   32'(out_ch),   32'(exp_rr_ch[i]));
      chk("rr.seq_data", 32'(out_data), 32'(exp_rr_data[i]));
    end

    // Sparse: make ch1 the last winner, then ch1/ch3 alternate starting at ch3.
    in_valid = 4'b0010;
    tick("sparse_pre");
    in_valid = 4'b1010;
    tick("sparse");
    chk("sparse.ch_a", 32'(out_ch), 32'd3);
    tick("sparse");
    chk("sparse.ch_b", 32'(out_ch), 32'd1);
    tick("sparse");
    chk("sparse.ch_c", 32'(out_ch), 32'd3);

    // Backpressure: hold ch0 word 0111 for three stalled cycles.
    in_data[3:0] = 4'b0111;
    in_valid = 4'b0001;
    tick("bp_load");
    chk("bp.load_data", 32'(out_data), 32'd7);
    chk("bp.load_ch",   32'(out_ch),   32'd0);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    repeat (3) tick("bp_stall");
    chk("bp.hold_data", 32'(out_data), 32'd7);
    out_ready = 1'b1;
    tick("bp_release");
    chk("bp.next_ch",    32'(out_ch),    32'd1);
    chk("bp.next_valid", 32'(out_valid), 32'd1);

    // Drain to idle: valid falls, data holds.
    in_valid = 4'b0000;
    tick("drain");
    chk("drain.valid", 32'(out_valid), 32'd0);
    chk("drain.data",  32'(out_data),  32'b1010);

`ifdef MUX_RR_SEL_OVERRIDE_EN
    // Override: only ch2 may win while sel_en is high.
    in_valid = 4'b1111;
    sel_en   = 1'b1;
    sel      = 2'd2;
    repeat (3) begin
      tick("ovr");
      chk("ovr.ch",   32'(out_ch),   32'd2);
      chk("ovr.data", 32'(out_data), 32'b1011);
    end
    sel_en = 1'b0;
    tick("ovr_off");
    chk("ovr_off.ch", 32'(out_ch), 32'd3);
`endif

    // Randomized traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 400; n++) begin
      in_valid  = N'($urandom);
      in_data   = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_RR_SEL_OVERRIDE_EN
      sel_en = ($urandom_range(0, 3) == 0);
      sel    = PTR_W'($urandom);
`endif
      if (n == 200) begin
        in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.out_ch",    32'(out_ch),    32'd0);
        chk("arst.in_ready",  32'(in_ready),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
